dsp_result_fifo: RTL
====================

Name: dsp_result_fifo

Overview:
- Downstream stage of dsp_slice. Captures each {resultb, resulta} pair into a small FIFO when the slice flags a valid result.
- Drains the FIFO as a serial stream of 2*DWIDTH words, A then B, over a valid/ready handshake.
- Decouples the slice's fixed-rate output from a consumer (bus or memory writer) that can stall.

Parameters:
- DWIDTH, 8, slice operand width; results are 2*DWIDTH bits.
- DEPTH, 4, FIFO entries, each holding one A/B pair; must be a power of two, at least 2.
- PTRW, 2, pointer width, equal to log2(DEPTH).

Ports:
- clk  in  1  clock, rising edge.
- clr  in  1  reset, synchronous, active-high.
- in_valid  in  1  slice result valid this cycle.
- resulta  in  2*DWIDTH  slice resulta.
- resultb  in  2*DWIDTH  slice resultb.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  2*DWIDTH  current word.
- out_sel  out  1  0 = word is resulta, 1 = word is resultb.
- count  out  PTRW+1  occupied entries, 0..DEPTH.
- full  out  1  count == DEPTH.
- overflow  out  1  sticky: a result was dropped.

Behaviour:
- Reset (clr high at posedge): wr_ptr = 0, rd_ptr = 0, count = 0, state = SEND_A, overflow = 0.
  - Outputs after reset: out_valid = 0, full = 0, out_sel = 0, out_data = 0.
  - Storage contents are don't-care.
  - clr mid-drain discards all entries; it has priority over every other event in that cycle.
- push = in_valid & (~full | pop). pop = out_valid & out_ready & (state == SEND_B).
- A push writes {resultb, resulta} at wr_ptr; wr_ptr increments modulo DEPTH (natural wrap).
- A pop increments rd_ptr modulo DEPTH.
- count update: +1 on push only, -1 on pop only, unchanged on push and pop together.
- Full with a same-cycle pop: the push is accepted. full stays 1 and count stays DEPTH.
- Full with no pop: the pair is dropped, overflow is set to 1 and held until clr, and the FIFO is unchanged.
- Latency, no fall-through: a pair pushed at edge N gives out_valid = 1 from edge N, visible in cycle N+1, if the FIFO was empty.
- out_valid = (count != 0). It is registered-state driven: out_data and out_sel are combinational from the head entry and state, with no dependence on in_valid.
- Serializer FSM, 2 states:
  - SEND_A: out_sel = 0, out_data = head.resulta. On out_valid & out_ready go to SEND_B. Otherwise hold.
  - SEND_B: out_sel = 1, out_data = head.resultb. On out_valid & out_ready, pop and go to SEND_A. Otherwise hold.
- While out_valid = 1 and out_ready = 0, out_data and out_sel stay stable (AXI-style rule). Pushes do not disturb the head.
- When empty: out_valid = 0, out_data = 0, state = SEND_A.
- Throughput: one word per cycle with out_ready held high, so one pair every 2 cycles. A producer pushing every cycle fills the FIFO.

Decomposition:
- Shared package dsp_pkg holds:
  - DWIDTH, defined once and shared with dsp_slice.
  - The result pair type: 4*DWIDTH bits, resultb in the upper half and resulta in the lower half.
  - State encodings: SEND_A = 1'b0, SEND_B = 1'b1.
- One natural sub-module: dsp_pair_fifo_mem, a DEPTH x 4*DWIDTH register array with synchronous write and asynchronous read at rd_ptr.
- The FSM, pointers and flags stay in the top module.

Test Plan:
- Single pair: after clr, push resulta = 16'h0006, resultb = 16'h001E, out_ready = 1.
  - Next cycle: out_valid = 1, out_sel = 0, out_data = 16'h0006.
  - Following cycle: out_sel = 1, out_data = 16'h001E.
  - Then out_valid = 0 and count = 0.
- Backpressure: push 1 pair with out_ready = 0 for 5 cycles.
  - out_data holds 16'h0006 with out_sel = 0 throughout.
  - Raise out_ready: both words emitted in 2 cycles.
- Fill and overflow: out_ready = 0, push 5 pairs (A = 16'h0001..16'h0005).
  - count = 4, full = 1, overflow = 1.
  - Draining yields A values 1, 2, 3, 4 only.
- Full with simultaneous pop: with the FIFO full and state SEND_B, out_ready = 1 and push A = 16'h00AA in the same cycle.
  - count stays 4, overflow stays 0, and 16'h00AA is drained last.
- Pointer wrap: push and drain 10 pairs interleaved.
  - Output order matches input order exactly.
  - count never exceeds 4.
- Reset mid-drain: clr while in SEND_B with 3 entries.
  - Next cycle: count = 0, out_valid = 0, out_sel = 0, overflow = 0.

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared definitions for the dsp_slice datapath and its result FIFO.
// Holds the operand width, the A/B result pair layout and serializer states.
package dsp_pkg;

    localparam int DWIDTH = 8;

    typedef struct packed {
        logic [2*DWIDTH-1:0] resultb;
        logic [2*DWIDTH-1:0] resulta;
    } pair_t;

    typedef enum logic {
        SEND_A = 1'b0,
        SEND_B = 1'b1
    } ser_state_t;

endpackage

// File: rtl/dsp_pair_fifo_mem.sv
// Storage array for result pairs.
// Synchronous write, asynchronous read at the read pointer.
module dsp_pair_fifo_mem
    import dsp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTRW  = 2
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [PTRW-1:0]       i_waddr,
    input  logic [4*DWIDTH-1:0]   i_wdata,
    input  logic [PTRW-1:0]       i_raddr,
    output logic [4*DWIDTH-1:0]   o_rdata
);

    logic [4*DWIDTH-1:0] r_mem [DEPTH];

    // Write one pair per accepted push; contents need no reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dsp_result_fifo.sv
// Result FIFO behind dsp_slice: buffers {resultb, resulta} pairs and
// drains them as a serial A-then-B word stream over valid/ready.
module dsp_result_fifo
    import dsp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTRW  = 2
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  in_valid,
    input  logic [2*DWIDTH-1:0]   resulta,
    input  logic [2*DWIDTH-1:0]   resultb,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*DWIDTH-1:0]   out_data,
    output logic                  out_sel,
    output logic [PTRW:0]         count,
    output logic                  full,
    output logic                  overflow
);

    localparam logic [PTRW:0] CNT_FULL = (PTRW+1)'(DEPTH);

    logic [PTRW-1:0]     r_wr_ptr;
    logic [PTRW-1:0]     r_rd_ptr;
    logic [PTRW:0]       r_count;
    logic                r_overflow;
    ser_state_t          r_state;
    ser_state_t          w_state_nxt;

    logic                w_full;
    logic                w_out_valid;
    logic                w_fire;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;
    pair_t               w_wdata;
    pair_t               w_head;
    logic [4*DWIDTH-1:0] w_head_bits;

    assign w_full      = (r_count == CNT_FULL);
    assign w_out_valid = (r_count != '0);
    assign w_fire      = w_out_valid & out_ready;
    assign w_pop       = w_fire & (r_state == SEND_B);
    // A pop in the same cycle frees the slot the push will use.
    assign w_push      = in_valid & (~w_full | w_pop);
    assign w_drop      = in_valid & w_full & ~w_pop;

    assign w_wdata = {resultb, resulta};
    assign w_head  = pair_t'(w_head_bits);

    dsp_pair_fifo_mem #(
        .DEPTH (DEPTH),
        .PTRW  (PTRW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_head_bits)
    );

    // Pointers, occupancy and sticky overflow; clr wins over all events.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Serializer state register.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= SEND_A;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: toggle A/B on every accepted word.
    always_comb begin
        w_state_nxt = r_state;
        if (w_fire) begin
            unique case (r_state)
                SEND_A:  w_state_nxt = SEND_B;
                SEND_B:  w_state_nxt = SEND_A;
                default: w_state_nxt = SEND_A;
            endcase
        end
    end

    // Word mux from head entry; zero when the FIFO is empty.
    always_comb begin
        out_data = '0;
        out_sel  = (r_state == SEND_B);
        if (w_out_valid) begin
            if (r_state == SEND_B) begin
                out_data = w_head.resultb;
            end else begin
                out_data = w_head.resulta;
            end
        end
    end

    assign out_valid = w_out_valid;
    assign count     = r_count;
    assign full      = w_full;
    assign overflow  = r_overflow;

endmodule
